window_gen: RTL
===============

# window_gen

Raster-scan 3x3 window generator feeding the multi-channel convolution stage. Accepts one multi-channel pixel per `valid_in` in row-major order, buffers the two previous image rows per channel, and emits a packed `IN_CH`×3×3 window with a one-cycle `valid_out` strobe for every fully-populated (unpadded) window position. It is the producer side of the packed-window interface that the per-channel convolution cores and channel summer consume.

## Interface
- `DATA_W`, 8, pixel width in bits (unsigned data, passed through untouched)
- `IN_CH`, 3, number of input channels
- `IMG_W`, 8, image width in pixels (≥3)
- `IMG_H`, 8, image height in pixels (≥3)

- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `valid_in`  in  1  pixel strobe; one pixel accepted per cycle when high
- `pix_in`  in  IN_CH*DATA_W  pixel, channel ch at `[DATA_W*(IN_CH-ch)-1 -: DATA_W]` (ch0 in MSBs)
- `valid_out`  out  1  one-cycle strobe, `window_out` valid
- `window_out`  out  IN_CH*DATA_W*9  packed window; channel ch slice at `[DATA_W*9*(IN_CH-ch)-1 -: DATA_W*9]`; within a slice tap k=r*3+c (r,c = 0..2, row 0 oldest/top, col 0 leftmost) at `[DATA_W*9 - DATA_W*k - 1 -: DATA_W]` (tap 0 in MSBs)
- `frame_done`  out  1  one-cycle strobe after last pixel of a frame is accepted

## Operation
- Column counter `col` (0..IMG_W-1) and row counter `row` (0..IMG_H-1), widths `$clog2` of the bound; both advance only on `valid_in`.
- On accepted pixel: `col` increments; at IMG_W-1 wraps to 0 and `row` increments; at (IMG_H-1, IMG_W-1) both wrap to 0 (next pixel is (0,0) of next frame).
- Two line buffers per channel, IMG_W entries each, indexed by `col`: line1 holds row-1, line0 holds row-2. On accept: line0[col] ← line1[col], line1[col] ← pixel.
- 3x3 shift window per channel: each accept shifts columns left and loads new right column {line0[col], line1[col], pix} (top, mid, bottom). Shift happens on every accept regardless of position.
- Window emitted when accepted pixel has row≥2 and col≥2; window then covers rows row-2..row, cols col-2..col. No padding: positions with row<2 or col<2 emit nothing. Windows per frame = (IMG_H-2)*(IMG_W-2).
- Left-edge columns carry stale data from the previous row's right end; they are never emitted because col<2 gates output.
- No backpressure: consumer always accepts. `valid_in` low cycles stall all state; gaps of any length are legal between any pixels, including mid-row.
- `window_out` is registered and holds its last value when `valid_out` is low.
- `frame_done` asserts the cycle after the (IMG_H-1, IMG_W-1) pixel is accepted, coincident with the last `valid_out`.

## Timing
- Latency: `valid_out`/`window_out` appear one cycle after the accepting edge of the window's bottom-right pixel.
- Throughput: one window per cycle with continuous `valid_in` inside the valid region.
- Reset (`rstn` low, asynchronous): `valid_out`=0, `frame_done`=0, `window_out`=0, `row`=`col`=0. Line-buffer and shift-register contents need not reset (outputs gated by counters).
- Reset mid-frame: partial frame discarded; first pixel after release is (0,0); no window emitted until row 2, col 2 of the new frame.
- Back-to-back frames: pixel (0,0) of frame N+1 may arrive the cycle after (IMG_H-1, IMG_W-1) of frame N; no bubble required, no window emitted across the frame boundary.

## Test plan
- Ramp frame, defaults, continuous `valid_in`: ch0=row*8+col, ch1=ch0+64, ch2=ch0+128 -> exactly 36 `valid_out` pulses; first one cycle after pixel (2,2): ch0 taps 0..8 = 0,1,2,8,9,10,16,17,18; ch2 tap 0 = 128; last window ch0 tap 8 = 63, `frame_done` coincident.
- Same frame with random 0-3 cycle gaps on `valid_in` -> identical window sequence and count; `valid_out` never high during gaps except the 1-cycle-latency pulse; `window_out` holds between pulses.
- Two back-to-back frames, second frame values +1 -> 72 pulses; first window of frame 2 ch0 taps = 1,2,3,9,10,11,17,18,19; no window built from frame-1 rows.
- Reset asserted after pixel (4,5), then fresh ramp frame -> all outputs 0 during reset; next 36 windows match the clean-frame expectations.
- Row-boundary check: at pixel (3,0),(3,1) -> no `valid_out`; at (3,2) -> ch0 taps 8,9,10,16,17,18,24,25,26.
- Parameter sweep IMG_W=3, IMG_H=3, IN_CH=1 -> single window equal to the 9 input pixels in order, `frame_done` same cycle.

Source files
------------

// File: rtl/window_gen.sv
// Raster-scan 3x3 window generator: two line buffers and a 3x3 shift window per
// channel, emitting a packed IN_CH x 3 x 3 window for every unpadded position.
module window_gen #(
  parameter int DATA_W = 8,
  parameter int IN_CH  = 3,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      valid_in,
  input  logic [IN_CH*DATA_W-1:0]   pix_in,
  output logic                      valid_out,
  output logic [IN_CH*DATA_W*9-1:0] window_out,
  output logic                      frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WW = IN_CH * DATA_W * 9;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST = RW'(2);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_out_q, frame_done_q;
  logic [WW-1:0] window_q, window_d;
  logic          emit, last_pix;

  logic [DATA_W-1:0] line0_q [IN_CH][IMG_W];
  logic [DATA_W-1:0] line1_q [IN_CH][IMG_W];
  logic [DATA_W-1:0] win_q   [IN_CH][3][3];
  logic [DATA_W-1:0] win_d   [IN_CH][3][3];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    col_d    = col_q;
    row_d    = row_q;
    win_d    = win_q;
    window_d = '0;
    emit     = valid_in && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
    last_pix = valid_in && (row_q == ROW_LAST) && (col_q == COL_LAST);

    if (valid_in) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      for (int ch = 0; ch < IN_CH; ch++) begin
        for (int r = 0; r < 3; r++) begin
          win_d[ch][r][0] = win_q[ch][r][1];
          win_d[ch][r][1] = win_q[ch][r][2];
        end
        win_d[ch][0][2] = line0_q[ch][col_q];
        win_d[ch][1][2] = line1_q[ch][col_q];
        win_d[ch][2][2] = pix_in[DATA_W*(IN_CH-ch)-1 -: DATA_W];
      end
    end

    // The registered output captures the window as it looks after this shift.
    for (int ch = 0; ch < IN_CH; ch++) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          window_d[DATA_W*9*(IN_CH-ch) - DATA_W*(r*3+c) - 1 -: DATA_W] = win_d[ch][r][c];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q        <= '0;
      row_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      window_q     <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      valid_out_q  <= emit;
      frame_done_q <= last_pix;
      if (emit) window_q <= window_d;
    end
  end

  // NOTE: line buffers and shift window are deliberately left unreset; the row/col
  // gating guarantees no stale entry ever reaches an emitted window.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    if (valid_in) begin
      for (int ch = 0; ch < IN_CH; ch++) begin
        line0_q[ch][col_q] <= line1_q[ch][col_q];
        line1_q[ch][col_q] <= pix_in[DATA_W*(IN_CH-ch)-1 -: DATA_W];
      end
    end
  end

  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;
  assign window_out = window_q;

endmodule
